instr_fetch_unit: RTL and testbench

INSTR_FETCH_UNIT -- requirements
Module: instr_fetch_unit

---
 rtl/instr_fetch_unit.sv | 151 +++++++++++++++
 tb/tb_instr_fetch_unit.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: issues in-order instruction memory reads at the
// current PC and holds the results in a small circular queue toward decode.
// A queue entry is allocated when its request is granted, so queue occupancy
// also counts the requests still waiting for a response.
// A redirect flushes the queue. Responses that are still in flight at that
// point are counted in drop_cnt and thrown away when they arrive.
//
// Ports
//   Clk_Core     in   core clock (rising edge)
//   Rst_Core     in   synchronous active-high reset
//   Fetch_PC     in   current PC from the program counter
//   Redirect     in   branch/jump taken this cycle
//   Fetch_Stall  out  PC must hold this cycle
//   Imem_Req     out  memory read request
//   Imem_Addr    out  request address (= Fetch_PC)
//   Imem_Gnt     in   memory accepts the request this cycle
//   Imem_Rvalid  in   response valid (in order, latency >= 1)
//   Imem_Rdata   in   response instruction word
//   Instr_Valid  out  head entry valid toward decode
//   Instr_Data   out  head instruction word
//   Instr_PC     out  head instruction address
//   Instr_Ready  in   decode consumes the head entry
module instr_fetch_unit #(
   parameter int DWIDTH = 32,
   parameter int QDEPTH = 4
) (
   input  logic              Clk_Core,
   input  logic              Rst_Core,
   input  logic [DWIDTH-1:0] Fetch_PC,
   input  logic              Redirect,
   output logic              Fetch_Stall,
   output logic              Imem_Req,
   output logic [DWIDTH-1:0] Imem_Addr,
   input  logic              Imem_Gnt,
   input  logic              Imem_Rvalid,
   input  logic [DWIDTH-1:0] Imem_Rdata,
   output logic              Instr_Valid,
   output logic [DWIDTH-1:0] Instr_Data,
   output logic [DWIDTH-1:0] Instr_PC,
   input  logic              Instr_Ready
);

   localparam int AW = $clog2(QDEPTH);
   localparam int PW = AW + 1;

   logic [PW-1:0]     wr_ptr;
   logic [PW-1:0]     rd_ptr;
   logic [PW-1:0]     fill_ptr;   // oldest entry still waiting for data
   logic [PW-1:0]     drop_cnt;
   logic [PW-1:0]     drop_next;
   logic [PW-1:0]     outstanding;
   logic [PW-1:0]     outstanding_after;

   logic [DWIDTH-1:0] pc_q   [QDEPTH];
   logic [DWIDTH-1:0] data_q [QDEPTH];
   logic [QDEPTH-1:0] ok_q;

   logic [AW-1:0]     wr_idx;
   logic [AW-1:0]     rd_idx;
   logic [AW-1:0]     fill_idx;

   logic              q_empty;
   logic              q_full;
   logic              dropping;
   logic              alloc;
   logic              fill;
   logic              drop_dec;
   logic              pop;

   assign wr_idx   = wr_ptr[AW-1:0];
   assign rd_idx   = rd_ptr[AW-1:0];
   assign fill_idx = fill_ptr[AW-1:0];

   assign q_empty  = (rd_ptr == wr_ptr);
   assign q_full   = ((wr_ptr - rd_ptr) == PW'(QDEPTH));
   assign dropping = (drop_cnt != '0);

   assign Imem_Req    = !Rst_Core && !Redirect && !q_full && !dropping;
   assign Imem_Addr   = Fetch_PC;
   assign alloc       = Imem_Req && Imem_Gnt;
   assign Fetch_Stall = Rst_Core || (!alloc && !Redirect);

   assign Instr_Valid = !Rst_Core && !q_empty && ok_q[rd_idx];
   assign Instr_Data  = data_q[rd_idx];
   assign Instr_PC    = pc_q[rd_idx];
   // A pop in a redirect cycle is cancelled: the entry is flushed instead.
   assign pop         = Instr_Valid && Instr_Ready && !Redirect;

   assign fill        = Imem_Rvalid && !dropping && (fill_ptr != wr_ptr);
   assign drop_dec    = Imem_Rvalid && dropping;

   // Requests still in flight once this cycle's response has been applied.
   assign outstanding       = wr_ptr - fill_ptr;
   assign outstanding_after = outstanding - PW'(fill);

   // Adding to the running count (rather than overwriting it) keeps a second
   // redirect during a drop window from losing the earlier in-flight responses.
   always_comb begin
      drop_next = drop_cnt - PW'(drop_dec);
      if (Redirect) begin
         drop_next = drop_next + outstanding_after;
      end
   end

   always_ff @(posedge Clk_Core) begin
      if (Rst_Core) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         fill_ptr <= '0;
         drop_cnt <= '0;
         ok_q     <= '0;
      end else begin
         drop_cnt <= drop_next;
         if (Redirect) begin
            rd_ptr   <= wr_ptr;
            fill_ptr <= wr_ptr;
            ok_q     <= '0;
         end else begin
            // fill_idx and wr_idx differ whenever both fire: equal indices
            // with unequal pointers means full, which blocks allocation.
            if (fill) begin
               ok_q[fill_idx] <= 1'b1;
               fill_ptr       <= fill_ptr + PW'(1);
            end
            if (alloc) begin
               ok_q[wr_idx] <= 1'b0;
               wr_ptr       <= wr_ptr + PW'(1);
            end
            if (pop) begin
               rd_ptr <= rd_ptr + PW'(1);
            end
         end
      end
   end

   always_ff @(posedge Clk_Core) begin
      if (alloc) begin
         pc_q[wr_idx] <= Fetch_PC;
      end
      if (fill) begin
         data_q[fill_idx] <= Imem_Rdata;
      end
   end

   a_no_orphan_rvalid: assert property (@(posedge Clk_Core) disable iff (Rst_Core)
      !(Imem_Rvalid && !dropping && (fill_ptr == wr_ptr)));

   a_drop_bound: assert property (@(posedge Clk_Core) disable iff (Rst_Core)
      drop_cnt <= PW'(QDEPTH));

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit. A queue-level reference model of the fetch
// buffer and an in-order memory model with random latency drive and check
// the DUT every cycle.
module tb_instr_fetch_unit;

   localparam int DW = 32;
   localparam int QD = 4;

   logic          clk = 1'b0;
   logic          Rst_Core;
   logic [DW-1:0] Fetch_PC;
   logic          Redirect;
   logic          Fetch_Stall;
   logic          Imem_Req;
   logic [DW-1:0] Imem_Addr;
   logic          Imem_Gnt;
   logic          Imem_Rvalid;
   logic [DW-1:0] Imem_Rdata;
   logic          Instr_Valid;
   logic [DW-1:0] Instr_Data;
   logic [DW-1:0] Instr_PC;
   logic          Instr_Ready;

   always #5 clk = ~clk;

   instr_fetch_unit #(.DWIDTH(DW), .QDEPTH(QD)) dut (
      .Clk_Core    (clk),
      .Rst_Core    (Rst_Core),
      .Fetch_PC    (Fetch_PC),
      .Redirect    (Redirect),
      .Fetch_Stall (Fetch_Stall),
      .Imem_Req    (Imem_Req),
      .Imem_Addr   (Imem_Addr),
      .Imem_Gnt    (Imem_Gnt),
      .Imem_Rvalid (Imem_Rvalid),
      .Imem_Rdata  (Imem_Rdata),
      .Instr_Valid (Instr_Valid),
      .Instr_Data  (Instr_Data),
      .Instr_PC    (Instr_PC),
      .Instr_Ready (Instr_Ready)
   );

   typedef struct {
      logic [DW-1:0] pc;
      logic [DW-1:0] data;
      bit            ok;
   } ent_t;

   typedef struct {
      logic [DW-1:0] addr;
      int unsigned   due;
   } mreq_t;

   ent_t        mq[$];     // fetch buffer contents as decode should see them
   mreq_t       mem[$];    // requests pending inside the memory
   int unsigned mdrop;     // in-flight responses that belong to flushed fetches
   int unsigned cyc;
   int          n_tests;
   int          n_fail;
   int          n_delivered;
   logic [DW-1:0] pc;
   bit          e_req;
   bit          e_valid;

   function automatic logic [DW-1:0] mem_word(logic [DW-1:0] a);
      return {a[15:0], a[31:16]} ^ 32'hC3A5_5A3C;
   endfunction

   task automatic chk(string tag, logic [DW-1:0] got, logic [DW-1:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   // Called just after a falling edge; returns just after the next one.
   task automatic run_cycle(bit rst, bit redir, logic [DW-1:0] tgt, bit gnt,
                            bit rdy, int unsigned resp_pct, int unsigned extra_lat);
      Rst_Core    = rst;
      Redirect    = redir;
      Imem_Gnt    = gnt;
      Instr_Ready = rdy;
      Fetch_PC    = pc;
      Imem_Rvalid = 1'b0;
      Imem_Rdata  = $urandom;
      if (!rst && mem.size() > 0 && mem[0].due <= cyc
          && $urandom_range(99) < resp_pct) begin
         Imem_Rvalid = 1'b1;
         Imem_Rdata  = mem_word(mem[0].addr);
         void'(mem.pop_front());
      end
      #1;
      e_req   = !rst && !redir && (mq.size() < QD) && (mdrop == 0);
      e_valid = !rst && (mq.size() > 0) && mq[0].ok;
      chk("imem_req", Imem_Req, e_req);
      chk("fetch_stall", Fetch_Stall, rst || (!(e_req && gnt) && !redir));
      chk("imem_addr", Imem_Addr, pc);
      chk("instr_valid", Instr_Valid, e_valid);
      if (e_valid) begin
         chk("instr_pc", Instr_PC, mq[0].pc);
         chk("instr_data", Instr_Data, mq[0].data);
      end
      @(posedge clk);
      if (rst) begin
         mq.delete();
         mem.delete();
         mdrop = 0;
         pc    = '0;
      end else begin
         if (Imem_Rvalid) begin
            if (mdrop > 0) begin
               mdrop--;
            end else begin
               for (int i = 0; i < mq.size(); i++) begin
                  if (!mq[i].ok) begin
                     mq[i].ok   = 1'b1;
                     mq[i].data = Imem_Rdata;
                     break;
                  end
               end
            end
         end
         if (e_valid && rdy && !redir) begin
            void'(mq.pop_front());
            n_delivered++;
         end
         if (e_req && gnt) begin
            mq.push_back('{pc: pc, data: '0, ok: 1'b0});
            mem.push_back('{addr: pc, due: cyc + 1 + $urandom_range(extra_lat)});
         end
         if (redir) begin
            for (int i = 0; i < mq.size(); i++) begin
               if (!mq[i].ok) mdrop++;
            end
            mq.delete();
            pc = tgt;
         end else if (e_req && gnt) begin
            pc = pc + 32'd4;
         end
      end
      cyc++;
      @(negedge clk);
   endtask

   initial begin
      n_tests     = 0;
      n_fail      = 0;
      n_delivered = 0;
      cyc         = 0;
      mdrop       = 0;
      pc          = '0;
      Rst_Core    = 1'b1;
      Redirect    = 1'b0;
      Imem_Gnt    = 1'b0;
      Instr_Ready = 1'b0;
      Imem_Rvalid = 1'b0;
      Imem_Rdata  = '0;
      Fetch_PC    = '0;
      @(negedge clk);

      // reset
      for (int i = 0; i < 3; i++) run_cycle(1, 0, 0, 1, 1, 0, 0);

      // steady flow: grant always, 1-cycle latency, decode always ready
      for (int i = 0; i < 20; i++) run_cycle(0, 0, 0, 1, 1, 100, 0);

      // backpressure then release
      for (int i = 0; i < 10; i++) run_cycle(0, 0, 0, 1, 0, 100, 0);
      for (int i = 0; i < 10; i++) run_cycle(0, 0, 0, 1, 1, 100, 0);

      // move to 0x10, let the drop window drain, then withhold grant
      run_cycle(0, 1, 32'h10, 1, 1, 100, 0);
      for (int i = 0; i < 4; i++) run_cycle(0, 0, 0, 0, 1, 100, 0);
      for (int i = 0; i < 3; i++) run_cycle(0, 0, 0, 0, 1, 100, 0);
      chk("grant_stall_pc", pc, 32'h10);

      // two outstanding requests, then redirect to 0x100
      run_cycle(0, 0, 0, 1, 1, 0, 0);
      run_cycle(0, 0, 0, 1, 1, 0, 0);
      run_cycle(0, 1, 32'h100, 1, 1, 0, 0);
      for (int i = 0; i < 8; i++) run_cycle(0, 0, 0, 1, 1, 100, 0);

      // fill the queue, then reset mid-operation
      for (int i = 0; i < 4; i++) run_cycle(0, 0, 0, 1, 0, 100, 0);
      run_cycle(1, 0, 0, 1, 1, 100, 0);
      for (int i = 0; i < 6; i++) run_cycle(0, 0, 0, 1, 1, 100, 0);

      // randomized traffic
      for (int i = 0; i < 4000; i++) begin
         run_cycle($urandom_range(199) == 0,
                   $urandom_range(99) < 5,
                   {$urandom_range(32'h0FFF), 2'b00},
                   $urandom_range(99) < 70,
                   $urandom_range(99) < 70,
                   60, 3);
      end

      // drain
      for (int i = 0; i < 30; i++) run_cycle(0, 0, 0, 1, 1, 100, 0);

      n_tests++;
      if (n_delivered < 100) begin
         n_fail++;
         $display("FAIL delivered: got %0d instructions expected at least 100", n_delivered);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
